// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter:
//   - arb_state_e : FSM state encoding (IDLE=0, WRITE=1)
//   - STATS_CNT_W : width of each per-requester write counter. The counters
//                   exist only when FIFO_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_e;

  localparam int STATS_CNT_W = 8;

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. The search starts one index after
// last_winner and wraps modulo NUM_REQ, so the requester that was served
// most recently has the lowest priority.
// Ports:
//   req         in  [NUM_REQ-1:0] active requests
//   last_winner in  [IDX_W-1:0]   index of the most recently served requester
//   valid       out               at least one request is active
//   winner      out [IDX_W-1:0]   selected index, meaningful when valid=1
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  // NOTE: every output gets a default before the loop. A path that leaves a
  // combinational output unassigned would infer a latch.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      // The first active index met after last_winner wins. The !valid guard
      // stops later candidates from overriding it.
      if (!valid && req[(int'(last_winner) + i) % NUM_REQ]) begin
        valid  = 1'b1;
        winner = IDX_W'((int'(last_winner) + i) % NUM_REQ);
      end
    end
  end

endmodule : rr_picker

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that gives NUM_REQ level-held write requesters access
// to one FIFO write port. The FSM works as follows:
//   IDLE : when a request is present and the FIFO is not full, the arbiter
//          latches the winner and its data.
//   WRITE: the arbiter issues wr_en and ack[winner] for one cycle, then
//          returns to IDLE.
// The arbiter can therefore write at most once every two cycles.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   req       in   [NUM_REQ] write requests, each held until acked
//   req_data  in   [NUM_REQ*DATA_WIDTH] requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   ack       out  [NUM_REQ] one-cycle pulse to the requester whose word was written
//   full      in   FIFO full flag
//   wr_en     out  FIFO write strobe
//   wr_data   out  [DATA_WIDTH] FIFO write data, 0 when wr_en=0
//   busy      out  high while in WRITE
//   wr_cnt    out  [NUM_REQ*8] per-requester wrapping write counters
//                  (present only when FIFO_ARB_STATS_EN is defined)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_CNT_W-1:0] wr_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        winner_q, winner_d;
  logic [IDX_W-1:0]        last_winner_q, last_winner_d;
  logic                    wr_en_q, wr_en_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_winner;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req         (req),
    .last_winner (last_winner_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  // The outputs of the WRITE cycle are computed at grant time and
  // registered. When the FSM enters WRITE, wr_en, ack and wr_data are
  // therefore already flop outputs. The captured word lives in wr_data_q, so
  // later changes on req_data cannot affect it.
  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    wr_en_d       = 1'b0;
    ack_d         = '0;
    wr_data_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid && !full) begin
          state_d             = WRITE;
          winner_d            = pick_winner;
          wr_en_d             = 1'b1;
          ack_d[pick_winner]  = 1'b1;
          wr_data_d           = req_data[int'(pick_winner) * DATA_WIDTH +: DATA_WIDTH];
        end
      end
      WRITE: begin
        // full is deliberately ignored here. It was low at grant, so the
        // write in flight always completes.
        state_d       = IDLE;
        last_winner_d = winner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their _d values from the same edge and simulation matches
  // the synthesized hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      winner_q      <= '0;
      // Resetting to the last index makes requester 0 win first.
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      wr_en_q       <= 1'b0;
      ack_q         <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      wr_en_q       <= wr_en_d;
      ack_q         <= ack_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign ack     = ack_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == WRITE);

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];
  logic [STATS_CNT_W-1:0] cnt_d [NUM_REQ];

  // Each counter wraps naturally at 2**STATS_CNT_W.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cnt_d[k] = cnt_q[k] + STATS_CNT_W'(ack_q[k]);
    end
  end

  // NOTE: these counters are a small register array, not a RAM, so they
  // take a reset. Reset is not appropriate for inferred memory macros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    wr_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      wr_cnt[k*STATS_CNT_W +: STATS_CNT_W] = cnt_q[k];
    end
  end
`endif

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench. The main instance has NUM_REQ=2 and is compared each
// cycle against a transaction-level model. A second instance with NUM_REQ=4
// is used to check the rotating grant order. The wr_cnt stats check runs
// only when FIFO_ARB_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic              full;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*8-1:0]   wr_cnt;
  logic [4*8-1:0]    wr_cnt4;
`endif

  logic [3:0]        req4;
  logic [4*DW-1:0]   req_data4;
  logic [3:0]        ack4;
  logic              wr_en4;
  logic [DW-1:0]     wr_data4;
  logic              busy4;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .full     (full),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_cnt   (wr_cnt)
`endif
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req4),
    .req_data (req_data4),
    .ack      (ack4),
    .full     (1'b0),
    .wr_en    (wr_en4),
    .wr_data  (wr_data4),
    .busy     (busy4)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_cnt   (wr_cnt4)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state. A grant is a pending transaction. Its effects
  // (strobe, data, ack) appear on the cycle after the grant.
  int            m_last;
  bit            m_pend;
  int            m_win;
  logic [NR-1:0] exp_ack;
  logic          exp_wr_en;
  logic [DW-1:0] exp_data;
  logic          exp_busy;

  // Advances one clock. Before the edge it applies the arbitration rules to
  // the inputs that the edge will sample, and it leaves the expected
  // post-edge outputs in exp_*.
  task automatic tick();
    exp_wr_en = 1'b0;
    exp_ack   = '0;
    exp_data  = '0;
    if (!rst_n) begin
      m_last = NR - 1;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_last = m_win;
      m_pend = 1'b0;
    end else if (req != '0 && !full) begin
      for (int i = 1; i <= NR; i++) begin
        int k;
        k = (m_last + i) % NR;
        if (req[k]) begin
          m_win = k;
          break;
        end
      end
      m_pend          = 1'b1;
      exp_wr_en       = 1'b1;
      exp_ack[m_win]  = 1'b1;
      exp_data        = req_data[m_win*DW +: DW];
    end
    exp_busy = m_pend;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; full = 1'b0; req_data = '0; req4 = '0; req_data4 = '0;
    tick();
    tick();
    checks++;
    if ({busy, wr_en, ack, wr_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset got busy=%b wr_en=%b ack=%b data=%h exp all zero", busy, wr_en, ack, wr_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] seen [$];
    req = 2'b11; req_data = {8'h3C, 8'hA5};
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({busy, wr_en, ack, wr_data} !== {exp_busy, exp_wr_en, exp_ack, exp_data}) begin
        errors++;
        $display("FAIL basic c%0d got %b_%b_%b_%h exp %b_%b_%b_%h", c, busy, wr_en, ack, wr_data,
                 exp_busy, exp_wr_en, exp_ack, exp_data);
      end
      if (wr_en === 1'b1) seen.push_back(wr_data);
      req = req & ~exp_ack;
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 8'hA5 || seen[1] !== 8'h3C) begin
      errors++;
      $display("FAIL basic_order got %0d writes exp A5 then 3C", seen.size());
    end
  endtask

  task automatic test_full();
    int writes = 0;
    req = 2'b01; req_data = {8'h00, 8'h5A}; full = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) full = 1'b0;
      tick();
      checks++;
      if ({busy, wr_en, ack, wr_data} !== {exp_busy, exp_wr_en, exp_ack, exp_data}) begin
        errors++;
        $display("FAIL full c%0d got %b_%b_%b_%h exp %b_%b_%b_%h", c, busy, wr_en, ack, wr_data,
                 exp_busy, exp_wr_en, exp_ack, exp_data);
      end
      if (wr_en === 1'b1) writes++;
      req = req & ~exp_ack;
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL full_writes got %0d exp 1", writes);
    end
  endtask

  task automatic test_full_in_write();
    int writes = 0;
    req = 2'b01; req_data = {8'h00, 8'hC3}; full = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (exp_wr_en) full = 1'b1;  // full rises during the WRITE cycle
      checks++;
      if ({busy, wr_en, ack, wr_data} !== {exp_busy, exp_wr_en, exp_ack, exp_data}) begin
        errors++;
        $display("FAIL full_in_write c%0d got %b_%b_%b_%h exp %b_%b_%b_%h", c, busy, wr_en, ack, wr_data,
                 exp_busy, exp_wr_en, exp_ack, exp_data);
      end
      if (wr_en === 1'b1) writes++;
      req = req & ~exp_ack;
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL full_in_write_count got %0d exp 1", writes);
    end
    full = 1'b0;
  endtask

  task automatic test_reset_in_write();
    req = 2'b01; req_data = {8'h77, 8'h11};
    tick();                      // grant 0
    req = req & ~exp_ack;
    tick();                      // WRITE, last winner becomes 0
    req = 2'b11;
    tick();                      // grant 1, now in WRITE
    checks++;
    if (ack !== 2'b10) begin
      errors++;
      $display("FAIL rst_in_write_pre got ack=%b exp 10", ack);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, wr_en, ack, wr_data} !== 12'h000) begin
      errors++;
      $display("FAIL rst_in_write got %b_%b_%b_%h exp all zero", busy, wr_en, ack, wr_data);
    end
    rst_n = 1'b1;
    tick();                      // requester 0 must win again after reset
    checks++;
    if ({busy, wr_en, ack, wr_data} !== {1'b1, 1'b1, 2'b01, 8'h11}) begin
      errors++;
      $display("FAIL rst_regrant got %b_%b_%b_%h exp 1_1_01_11", busy, wr_en, ack, wr_data);
    end
    req = req & ~exp_ack;
    while (req != '0 || m_pend) begin
      tick();
      req = req & ~exp_ack;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++) if (!req[k] && $urandom_range(0, 2) == 0) req[k] = 1'b1;
      req_data = NR*DW'($urandom);
      full     = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({busy, wr_en, ack, wr_data} !== {exp_busy, exp_wr_en, exp_ack, exp_data}) begin
        errors++;
        $display("FAIL random c%0d got %b_%b_%b_%h exp %b_%b_%b_%h", c, busy, wr_en, ack, wr_data,
                 exp_busy, exp_wr_en, exp_ack, exp_data);
      end
      req = req & ~exp_ack;
    end
    full = 1'b0;
    req  = '0;
    tick();
    tick();
  endtask

  task automatic test_four_req();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req4 = 4'hF; req_data4 = 32'h44332211;
    for (int g = 0; g < 8; g++) begin
      for (int t = 0; t < 10 && ack4 == '0; t++) begin
        @(posedge clk);
        #1;
      end
      checks++;
      if (ack4 !== 4'(1 << (g % 4))) begin
        errors++;
        $display("FAIL four_req grant%0d got ack=%b exp %b", g, ack4, 4'(1 << (g % 4)));
      end
      @(posedge clk);
      #1;
    end
    req4 = '0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    int acks = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 2'b01;
    for (int c = 0; c < 700 && acks < 300; c++) begin
      tick();
      if (exp_ack[0]) acks++;
      if (acks == 300) req = '0;
    end
    tick();
    tick();
    checks++;
    if (wr_cnt[7:0] !== 8'(acks) || acks != 300) begin
      errors++;
      $display("FAIL stats got wr_cnt0=%0d (acks %0d) exp 44", wr_cnt[7:0], acks);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_in_write();
    test_reset_in_write();
    test_random();
    test_four_req();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of write requesters (legal 2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester write request, level, held until acked.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port ack  output  NUM_REQ  one-cycle pulse to the requester whose word was written.
REQ-008 SHALL have port full  input  1  FIFO full flag, already in clk domain.
REQ-009 SHALL have port wr_en  output  1  one-cycle FIFO write strobe.
REQ-010 SHALL have port wr_data  output  DATA_WIDTH  FIFO write data, valid while wr_en=1.
REQ-011 SHALL have port busy  output  1  high while in state WRITE.

Function
REQ-012 SHALL implement FSM states IDLE and WRITE.
REQ-013 IDLE: if any req=1 and full=0, SHALL latch round-robin winner index and its req_data, then go to WRITE next cycle.
REQ-014 IDLE: if full=1 or no req, SHALL stay in IDLE; no grant, no pointer change.
REQ-015 WRITE: SHALL drive wr_en=1, wr_data=latched data, ack[winner]=1 for exactly this cycle, then return to IDLE.
REQ-016 Latency: req sampled high in cycle N (full=0, IDLE) SHALL give wr_en/ack in cycle N+1; max throughput one write per 2 cycles.
REQ-017 Round-robin: search starts at index last_winner+1 modulo NUM_REQ; after each WRITE last_winner SHALL update to winner.
REQ-018 Simultaneous requests SHALL be served in rotating order; no requester waits more than NUM_REQ grants.
REQ-019 full rising while in WRITE SHALL NOT cancel the write (full was low at grant).
REQ-020 Requester data SHALL be captured at grant; later req_data changes do not affect wr_data.
REQ-021 wr_data SHALL be 0 whenever wr_en=0.
REQ-022 Requester dropping req before ack is illegal; the latched word is still written.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state IDLE, wr_en=0, ack=0, wr_data=0, busy=0, last_winner=NUM_REQ-1 (so index 0 wins first).
REQ-024 Reset during WRITE SHALL abort the write; wr_en is 0 in the following cycle.

Configuration
REQ-025 Macro FIFO_ARB_STATS_EN: when defined, SHALL add output wr_cnt (NUM_REQ*8 bits), one 8-bit wrapping counter per requester, incremented on its ack, reset to 0.
REQ-026 Without FIFO_ARB_STATS_EN, port wr_cnt and counters SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, WRITE=1) and the stats counter width constant (8).
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req, last_winner; outputs valid, winner index).

Verification
REQ-029 Reset then req=2'b11, data0=8'hA5, data1=8'h3C, full=0 -> writes A5 then 3C, acks 01 then 10, one write per 2 cycles.
REQ-030 req=2'b01 held, full=1 for 5 cycles then 0 -> no wr_en during full; single write 1 cycle after full falls is sampled low.
REQ-031 Grant taken, full rises in WRITE cycle -> write completes, wr_en=1 exactly once.
REQ-032 rst_n=0 in WRITE cycle -> wr_en=0 next cycle, next grant goes to requester 0.
REQ-033 NUM_REQ=4, all req held for 8 grants -> ack order 0,1,2,3,0,1,2,3.
REQ-034 With FIFO_ARB_STATS_EN, 300 writes from requester 0 -> wr_cnt[7:0]=8'd44 (wrap).
